// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, fetch-buffer entry
// layout and alignment helper.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_SPACE,
      FLUSH,
      HALT
   } fetch_state_e;

   localparam int INSTR_BYTES   = 4;
   localparam int FETCH_PC_W    = 64;
   localparam int FETCH_INSTR_W = 32;

   // Entry is sized for the widest supported configuration; narrower builds zero-extend.
   typedef struct packed {
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return addr_lsb == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched instructions; synchronous clear has
// priority over push and pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding imem request at a time,
// buffers responses for decode and handles branch redirects and misaligned targets.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | just out of reset, no request yet
// REQ        | request for PC outstanding on imemReq/imemAddr
// WAIT_SPACE | buffer full, no request until decode pops
// FLUSH      | old request still in flight, its response will be dropped
// HALT       | misaligned redirect seen, fetch stopped until aligned redirect
module instruction_fetch_controller
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH    = 64,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int                  FIFO_DEPTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imemReq,
   output logic [PC_WIDTH-1:0]    imemAddr,
   input  logic                   imemAck,
   input  logic [INSTR_WIDTH-1:0] imemData,
   input  logic                   redirectValid,
   input  logic [PC_WIDTH-1:0]    redirectTarget,
   output logic                   fetchValid,
   output logic [INSTR_WIDTH-1:0] fetchInstr,
   output logic [PC_WIDTH-1:0]    fetchPC,
   input  logic                   fetchReady,
   output logic                   fetchFault
);

   localparam int ENTRY_W = $bits(fetch_entry_t);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] flush_addr_q, flush_addr_d;
   logic                fault_q, fault_d;

   logic                fifo_clr, fifo_push, fifo_pop;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count, count_if_push;
   fetch_entry_t        push_entry, head_entry;
   logic                req_outstanding, target_aligned;

   assign req_outstanding = (state_q == REQ) || (state_q == FLUSH);
   assign target_aligned  = is_word_aligned(redirectTarget[1:0]);

   assign imemReq    = req_outstanding;
   assign imemAddr   = (state_q == FLUSH) ? flush_addr_q : pc_q;
   assign fetchFault = fault_q;

   assign fetchValid = !fifo_empty;
   assign fifo_pop   = fetchValid && fetchReady;
   assign fetchInstr = fetchValid ? head_entry.instr[INSTR_WIDTH-1:0] : '0;
   assign fetchPC    = fetchValid ? head_entry.pc[PC_WIDTH-1:0] : '0;

   assign push_entry.pc    = FETCH_PC_W'(pc_q);
   assign push_entry.instr = FETCH_INSTR_W'(imemData);

   // Occupancy at the end of this cycle if the current ack gets pushed.
   assign count_if_push = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      flush_addr_d = flush_addr_q;
      fault_d      = fault_q;
      fifo_clr     = 1'b0;
      fifo_push    = 1'b0;

      if (redirectValid) begin
         fifo_clr = 1'b1;
         if (target_aligned) begin
            pc_d    = redirectTarget;
            fault_d = 1'b0;
         end else begin
            fault_d = 1'b1;
         end
         // An unacked request keeps its address on the bus until the memory answers.
         if (req_outstanding && !imemAck) begin
            state_d = FLUSH;
            if (state_q == REQ) begin
               flush_addr_d = pc_q;
            end
         end else begin
            state_d = target_aligned ? REQ : HALT;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
            end
            REQ: begin
               if (imemAck) begin
                  fifo_push = !fifo_full;
                  pc_d      = pc_q + PC_WIDTH'(INSTR_BYTES);
                  state_d   = (count_if_push < CNT_W'(FIFO_DEPTH)) ? REQ : WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (fifo_pop) begin
                  state_d = REQ;
               end
            end
            FLUSH: begin
               if (imemAck) begin
                  state_d = fault_q ? HALT : REQ;
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         flush_addr_q <= RESET_PC;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         flush_addr_q <= flush_addr_d;
         fault_q      <= fault_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fetch_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (push_entry),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller: sequential fetch, slow memory,
// back-pressure, redirect flush, misaligned halt, PC wrap and async reset.
module tb_instruction_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imemReq;
   logic [63:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [63:0] redirectTarget;
   logic        fetchValid;
   logic [31:0] fetchInstr;
   logic [63:0] fetchPC;
   logic        fetchReady;
   logic        fetchFault;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instruction_fetch_controller dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imemReq        (imemReq),
      .imemAddr       (imemAddr),
      .imemAck        (imemAck),
      .imemData       (imemData),
      .redirectValid  (redirectValid),
      .redirectTarget (redirectTarget),
      .fetchValid     (fetchValid),
      .fetchInstr     (fetchInstr),
      .fetchPC        (fetchPC),
      .fetchReady     (fetchReady),
      .fetchFault     (fetchFault)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      imemAck        = 1'b0;
      imemData       = '0;
      redirectValid  = 1'b0;
      redirectTarget = '0;
      fetchReady     = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},   imemReq,    64'd0);
      check_eq({tag, "_addr"},  imemAddr,   64'd0);
      check_eq({tag, "_valid"}, fetchValid, 64'd0);
      check_eq({tag, "_instr"}, fetchInstr, 64'd0);
      check_eq({tag, "_pc"},    fetchPC,    64'd0);
      check_eq({tag, "_fault"}, fetchFault, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      step();
      step();
      check_reset_outputs("rst");

      // Sequential fetch, same-cycle ack, decode always ready.
      rst_n      = 1'b1;
      fetchReady = 1'b1;
      step();
      check_eq("seq_valid0", fetchValid, 64'd0);
      for (int i = 0; i < 4; i++) begin
         check_eq("seq_req", imemReq, 64'd1);
         check_eq("seq_addr", imemAddr, 64'(4 * i));
         if (i > 0) begin
            check_eq("seq_valid", fetchValid, 64'd1);
            check_eq("seq_pc", fetchPC, 64'(4 * (i - 1)));
            check_eq("seq_instr", fetchInstr, 64'(32'hA000_0000 + 32'(4 * (i - 1))));
         end
         imemAck  = 1'b1;
         imemData = 32'hA000_0000 + 32'(4 * i);
         step();
      end
      imemAck = 1'b0;

      // Slow memory: address held three cycles, ack on the third.
      do_reset();
      fetchReady = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         check_eq("slow_req", imemReq, 64'd1);
         check_eq("slow_addr", imemAddr, 64'd0);
         check_eq("slow_valid", fetchValid, 64'd0);
         if (i == 2) begin
            imemAck  = 1'b1;
            imemData = 32'hF842_802A;
         end
         step();
      end
      imemAck = 1'b0;
      check_eq("slow_valid_after", fetchValid, 64'd1);
      check_eq("slow_instr", fetchInstr, 64'h0000_0000_F842_802A);
      check_eq("slow_pc", fetchPC, 64'd0);
      check_eq("slow_next_addr", imemAddr, 64'd4);

      // Asynchronous reset while the request to 4 is waiting.
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");

      // Back-pressure: two entries fill the buffer and fetch stalls.
      do_reset();
      step();
      imemAck  = 1'b1;
      imemData = 32'hD000_0000;
      step();
      check_eq("bp_addr1", imemAddr, 64'd4);
      check_eq("bp_req1", imemReq, 64'd1);
      imemData = 32'hD000_0004;
      step();
      imemAck = 1'b0;
      check_eq("bp_stall_req", imemReq, 64'd0);
      check_eq("bp_head_pc", fetchPC, 64'd0);
      step();
      check_eq("bp_stall_req2", imemReq, 64'd0);
      fetchReady = 1'b1;
      step();
      fetchReady = 1'b0;
      check_eq("bp_resume_req", imemReq, 64'd1);
      check_eq("bp_resume_addr", imemAddr, 64'd8);
      check_eq("bp_head2_pc", fetchPC, 64'd4);
      check_eq("bp_head2_instr", fetchInstr, 64'h0000_0000_D000_0004);
      fetchReady = 1'b1;
      step();
      check_eq("bp_drained", fetchValid, 64'd0);

      // Redirect while the request to 8 is still outstanding.
      do_reset();
      fetchReady = 1'b1;
      step();
      imemAck  = 1'b1;
      imemData = 32'h1111_0000;
      step();
      imemData = 32'h1111_0004;
      step();
      check_eq("rd_addr8", imemAddr, 64'd8);
      imemAck        = 1'b0;
      redirectValid  = 1'b1;
      redirectTarget = 64'h40;
      step();
      redirectValid = 1'b0;
      check_eq("rd_flush_valid", fetchValid, 64'd0);
      check_eq("rd_flush_req", imemReq, 64'd1);
      check_eq("rd_flush_addr", imemAddr, 64'd8);
      step();
      imemAck  = 1'b1;
      imemData = 32'hDEAD_BEEF;
      step();
      check_eq("rd_drop_valid", fetchValid, 64'd0);
      check_eq("rd_target_req", imemReq, 64'd1);
      check_eq("rd_target_addr", imemAddr, 64'h40);
      imemData = 32'h1111_0040;
      step();
      imemAck = 1'b0;
      check_eq("rd_new_valid", fetchValid, 64'd1);
      check_eq("rd_new_pc", fetchPC, 64'h40);
      check_eq("rd_new_instr", fetchInstr, 64'h0000_0000_1111_0040);

      // Misaligned redirect coinciding with an ack goes straight to HALT.
      imemAck        = 1'b1;
      imemData       = 32'h2222_0044;
      redirectValid  = 1'b1;
      redirectTarget = 64'h42;
      step();
      imemAck       = 1'b0;
      redirectValid = 1'b0;
      check_eq("mis_fault", fetchFault, 64'd1);
      check_eq("mis_valid", fetchValid, 64'd0);
      check_eq("mis_pc_kept", imemAddr, 64'h44);
      for (int i = 0; i < 3; i++) begin
         check_eq("mis_halt_req", imemReq, 64'd0);
         step();
      end
      check_eq("mis_fault_sticky", fetchFault, 64'd1);
      redirectValid  = 1'b1;
      redirectTarget = 64'h80;
      step();
      redirectValid = 1'b0;
      check_eq("mis_clear_fault", fetchFault, 64'd0);
      check_eq("mis_resume_req", imemReq, 64'd1);
      check_eq("mis_resume_addr", imemAddr, 64'h80);

      // Misaligned redirect with the request to 0x80 outstanding: drain, then halt.
      redirectValid  = 1'b1;
      redirectTarget = 64'h81;
      step();
      redirectValid = 1'b0;
      check_eq("misf_fault", fetchFault, 64'd1);
      check_eq("misf_req", imemReq, 64'd1);
      check_eq("misf_addr", imemAddr, 64'h80);
      imemAck  = 1'b1;
      imemData = 32'h3333_0080;
      step();
      imemAck = 1'b0;
      check_eq("misf_halt_req", imemReq, 64'd0);
      check_eq("misf_halt_valid", fetchValid, 64'd0);

      // PC wrap at the top of the address space.
      redirectValid  = 1'b1;
      redirectTarget = 64'hFFFF_FFFF_FFFF_FFFC;
      fetchReady     = 1'b0;
      step();
      redirectValid = 1'b0;
      check_eq("wrap_addr_top", imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("wrap_fault", fetchFault, 64'd0);
      imemAck  = 1'b1;
      imemData = 32'hCAFE_0000;
      step();
      imemAck = 1'b0;
      check_eq("wrap_addr_zero", imemAddr, 64'd0);
      check_eq("wrap_req", imemReq, 64'd1);
      check_eq("wrap_fetch_pc", fetchPC, 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("wrap_fetch_instr", fetchInstr, 64'h0000_0000_CAFE_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
